// File: rtl/hs_fifo_responder.sv
// Buffered req/ack responder: a valid/ready push stream fills a circular FIFO,
// and each downstream req is answered with a registered one-cycle ack carrying the head word.
module hs_fifo_responder #(
   parameter int data_width = 32,
   parameter int depth      = 8,
   parameter int addr_width = 3
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  s_valid,
   output logic                  s_ready,
   input  logic [data_width-1:0] s_data,
   input  logic                  req,
   output logic                  ack,
   output logic [data_width-1:0] dout,
   output logic [addr_width:0]   level,
   output logic [31:0]           count,
   output logic [31:0]           starve
);

   localparam logic [addr_width:0] full_level = (addr_width + 1)'(depth);

   logic [data_width-1:0] mem [depth];
   logic [addr_width-1:0] wr_ptr;
   logic [addr_width-1:0] rd_ptr;
   logic                  push;
   logic                  grant;
   logic                  starving;

   function automatic logic [31:0] sat_inc(input logic [31:0] v);
      return (v == '1) ? v : v + 32'd1;
   endfunction

   assign s_ready  = ~rst & (level != full_level);
   assign push     = s_valid & s_ready;
   // ~ack blocks back-to-back grants so a requester may drop req one cycle late
   assign grant    = req & ~ack & (level != '0);
   assign starving = req & ~ack & (level == '0);

   always_ff @(posedge clk) begin
      if (push) begin
         mem[wr_ptr] <= s_data;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         ack    <= 1'b0;
         dout   <= '0;
         level  <= '0;
         count  <= '0;
         starve <= '0;
      end else begin
         ack <= grant;
         if (push) begin
            wr_ptr <= wr_ptr + addr_width'(1);
         end
         if (grant) begin
            dout   <= mem[rd_ptr];
            rd_ptr <= rd_ptr + addr_width'(1);
            count  <= count + 32'd1;
         end
         if (starving) begin
            starve <= sat_inc(starve);
         end
         case ({push, grant})
            2'b10:   level <= level + (addr_width + 1)'(1);
            2'b01:   level <= level - (addr_width + 1)'(1);
            default: level <= level;
         endcase
      end
   end

endmodule

// File: tb/tb_hs_fifo_responder.sv
// Directed bench for hs_fifo_responder: linear stimulus with hand-computed expectations.
module tb_hs_fifo_responder;

   logic        clk;
   logic        rst;
   logic        s_valid;
   logic        s_ready;
   logic [31:0] s_data;
   logic        req;
   logic        ack;
   logic [31:0] dout;
   logic [3:0]  level;
   logic [31:0] count;
   logic [31:0] starve;

   int n_cmp;
   int n_err;
   logic prev_ack;

   hs_fifo_responder #(.data_width(32), .depth(8), .addr_width(3)) dut (
      .clk(clk), .rst(rst), .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data),
      .req(req), .ack(ack), .dout(dout), .level(level), .count(count), .starve(starve)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   // advance one edge, sample 1ns later, and confirm ack never pulses twice in a row
   task automatic step();
      prev_ack = ack;
      @(posedge clk);
      #1;
      chk("no_b2b_ack", 32'(prev_ack & ack), 0);
   endtask

   initial begin
      n_cmp = 0;
      n_err = 0;
      rst = 1'b1; s_valid = 1'b0; s_data = '0; req = 1'b0; prev_ack = 1'b0;
      @(posedge clk); #1;
      @(posedge clk); #1;
      chk("rst_ack", 32'(ack), 0);
      chk("rst_dout", dout, 0);
      chk("rst_level", 32'(level), 0);
      chk("rst_count", count, 0);
      chk("rst_starve", starve, 0);
      chk("rst_s_ready", 32'(s_ready), 0);
      rst = 1'b0;
      #1;
      chk("post_rst_s_ready", 32'(s_ready), 1);

      // push 1,2,3 back-to-back with req high
      req = 1'b1; s_valid = 1'b1; s_data = 1;
      step(); chk("t1_e1_ack", 32'(ack), 0); chk("t1_e1_level", 32'(level), 1);
      chk("t1_e1_starve", starve, 1);
      s_data = 2;
      step(); chk("t1_e2_ack", 32'(ack), 1); chk("t1_e2_dout", dout, 1);
      chk("t1_e2_level", 32'(level), 1);
      s_data = 3;
      step(); chk("t1_e3_ack", 32'(ack), 0); chk("t1_e3_level", 32'(level), 2);
      s_valid = 1'b0;
      step(); chk("t1_e4_ack", 32'(ack), 1); chk("t1_e4_dout", dout, 2);
      step(); chk("t1_e5_ack", 32'(ack), 0);
      step(); chk("t1_e6_ack", 32'(ack), 1); chk("t1_e6_dout", dout, 3);
      chk("t1_count", count, 3); chk("t1_level", 32'(level), 0);
      req = 1'b0;
      step(); chk("t1_e7_ack", 32'(ack), 0); chk("t1_starve", starve, 1);

      // fill to full with req low; overflow word 99 must be dropped
      for (int i = 0; i < 8; i++) begin
         s_valid = 1'b1; s_data = 32'(10 + i);
         step();
      end
      chk("t2_full_level", 32'(level), 8);
      chk("t2_full_s_ready", 32'(s_ready), 0);
      s_data = 99;
      step(); chk("t2_drop_level", 32'(level), 8);
      req = 1'b1;
      step(); chk("t2_g0_ack", 32'(ack), 1); chk("t2_g0_dout", dout, 10);
      chk("t2_g0_level", 32'(level), 7); chk("t2_g0_s_ready", 32'(s_ready), 1);
      s_valid = 1'b0;
      step(); chk("t2_g0_gap", 32'(ack), 0); chk("t2_g0_hold", dout, 10);
      for (int i = 1; i < 8; i++) begin
         step(); chk("t2_ack", 32'(ack), 1); chk("t2_dout", dout, 32'(10 + i));
         step(); chk("t2_gap", 32'(ack), 0); chk("t2_hold", dout, 32'(10 + i));
      end
      chk("t2_level", 32'(level), 0);
      chk("t2_count", count, 11);
      chk("t2_starve", starve, 1);

      // starve for 4 edges, then push 42 at an edge that still sees an empty FIFO
      for (int i = 0; i < 4; i++) step();
      chk("t3_starve_pre", starve, 5);
      s_valid = 1'b1; s_data = 42;
      step(); chk("t3_push_starve", starve, 6); chk("t3_push_ack", 32'(ack), 0);
      s_valid = 1'b0;
      step(); chk("t3_ack", 32'(ack), 1); chk("t3_dout", dout, 42);
      chk("t3_starve_stop", starve, 6);
      step(); chk("t3_gap", 32'(ack), 0); chk("t3_starve_gap", starve, 6);
      req = 1'b0;
      step(); chk("t3_starve_end", starve, 6); chk("t3_count", count, 12);

      // hold level at 4 while streaming 40 words through wrapping pointers
      for (int i = 0; i < 4; i++) begin
         s_valid = 1'b1; s_data = 32'(100 + i);
         step();
      end
      chk("t4_level_init", 32'(level), 4);
      req = 1'b1;
      for (int i = 0; i < 36; i++) begin
         s_valid = 1'b1; s_data = 32'(104 + i);
         step(); chk("t4_ack", 32'(ack), 1); chk("t4_dout", dout, 32'(100 + i));
         chk("t4_level_pg", 32'(level), 4);
         s_valid = 1'b0;
         step(); chk("t4_gap", 32'(ack), 0); chk("t4_level_gap", 32'(level), 4);
      end
      for (int i = 0; i < 4; i++) begin
         step(); chk("t4_drain_ack", 32'(ack), 1); chk("t4_drain_dout", dout, 32'(136 + i));
         step(); chk("t4_drain_gap", 32'(ack), 0);
      end
      req = 1'b0;
      chk("t4_level", 32'(level), 0);
      chk("t4_count", count, 52);
      chk("t4_starve", starve, 6);

      // requester drops req one cycle after each ack
      for (int i = 0; i < 3; i++) begin
         s_valid = 1'b1; s_data = 32'(200 + i);
         step();
      end
      s_valid = 1'b0;
      for (int i = 0; i < 3; i++) begin
         req = 1'b1;
         step(); chk("t5_ack", 32'(ack), 1); chk("t5_dout", dout, 32'(200 + i));
         step(); chk("t5_blocked", 32'(ack), 0);
         req = 1'b0;
         step(); chk("t5_idle", 32'(ack), 0);
      end
      chk("t5_level", 32'(level), 0);
      chk("t5_count", count, 55);

      // reset mid-operation with level 5 and ack high
      for (int i = 0; i < 6; i++) begin
         s_valid = 1'b1; s_data = 32'(300 + i);
         step();
      end
      s_valid = 1'b0; req = 1'b1;
      step(); chk("t6_pre_ack", 32'(ack), 1); chk("t6_pre_dout", dout, 300);
      chk("t6_pre_level", 32'(level), 5);
      rst = 1'b1; req = 1'b0;
      step();
      chk("t6_ack", 32'(ack), 0); chk("t6_level", 32'(level), 0);
      chk("t6_count", count, 0); chk("t6_dout", dout, 0);
      chk("t6_starve", starve, 0); chk("t6_s_ready_rst", 32'(s_ready), 0);
      rst = 1'b0;
      #1;
      chk("t6_s_ready", 32'(s_ready), 1);
      s_valid = 1'b1; s_data = 7;
      step(); chk("t6_push_level", 32'(level), 1);
      s_valid = 1'b0; req = 1'b1;
      step(); chk("t6_ack7", 32'(ack), 1); chk("t6_dout7", dout, 7);
      chk("t6_count1", count, 1);
      req = 1'b0;
      step();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule

// File: doc/hs_fifo_responder.md
# hs_fifo_responder

Buffered responder for the dataflow req/ack pull protocol. It accepts words from a valid/ready push stream into a circular FIFO. It serves them one per grant to a downstream requester such as an `in` async operator or a consumer, replacing the synthetic producer with real buffered data. It is the responder end of the protocol: it never initiates, it only answers `req` with a one-cycle `ack` carrying data.

## Interface
Parameters:
- `data_width`, 32, word width.
- `depth`, 8, FIFO entries; power of two, at least 2.
- `addr_width`, 3, equals log2(`depth`).

Ports:
- `clk`  in  1  clock; all state updates on the rising edge.
- `rst`  in  1  reset, synchronous, active-high.
- `s_valid`  in  1  push stream word valid.
- `s_ready`  out  1  push stream can accept.
- `s_data`  in  `data_width`  push stream word.
- `req`  in  1  level request from the downstream requester.
- `ack`  out  1  registered one-cycle grant pulse.
- `dout`  out  `data_width`  registered granted word; valid in the `ack` cycle and held afterwards.
- `level`  out  `addr_width`+1  current FIFO occupancy.
- `count`  out  32  total grants issued since reset.
- `starve`  out  32  cycles in which `req` was high, `ack` was low and the FIFO was empty.

## Operation
- Storage: `mem[depth]`, with `wr_ptr` and `rd_ptr` each `addr_width` bits. Pointers wrap modulo `depth` by natural overflow.
- Push:
  - `s_ready = ~rst & (level != depth)`, combinational from registered `level`.
  - When `s_valid & s_ready`: write `mem[wr_ptr] <= s_data` and advance `wr_ptr`.
- Grant: when `req & ~ack & (level != 0)`:
  - `ack <= 1`, `dout <= mem[rd_ptr]`.
  - Advance `rd_ptr`; `count <= count + 1`.
- Otherwise `ack <= 0`. `dout` holds its last value.
- `ack` is never high on two consecutive cycles, because the `~ack` term blocks a back-to-back grant. This tolerates a requester that drops `req` one cycle after seeing `ack`.
- Occupancy update:
  - `level` += 1 on push only, −1 on grant only.
  - Unchanged when a push and a grant happen in the same cycle.
- There is no bypass. A word pushed at edge t is grantable at edge t+1 at the earliest.
- Starvation: when `req & ~ack & (level == 0)`, `starve <= starve + 1`. This counter saturates at 2^32−1; `count` wraps.
- `count` and `starve` are 32-bit and increment in the same cycles as the events above.

## Timing
- Reset, while `rst` is high at an edge:
  - `ack`=0, `dout`=0, `level`=0, `count`=0, `starve`=0.
  - Both pointers are 0.
  - `s_ready`=0 during `rst`, and 1 in the first cycle after `rst` falls.
- Reset in mid-operation discards all buffered words and any pending grant. `mem` contents are not cleared.
- Push-to-`ack` latency: 2 edges when `req` is already high. The push registers at edge t, and `ack`/`dout` are registered at edge t+1.
- Sustained throughput: one grant per 2 cycles, as set by the `~ack` rule.
- Full (`level == depth`):
  - `s_ready`=0 and the push is ignored, even if a grant happens in the same cycle.
  - `s_ready` rises in the cycle after the grant.
- Empty with `req` high: no `ack`, and `starve` increments each cycle.
- Simultaneous push and grant at `level`=1: the grant returns the old head and `level` stays 1.

## Test plan
- Reset, then push 1,2,3 on back-to-back cycles with `req` held high.
  - `ack` pulses on alternating cycles with `dout` = 1, 2, 3.
  - Final `count`=3, `level`=0.
- Push 8 words (10..17) with `req` low.
  - `level`=8 and `s_ready`=0; a 9th push of 99 is dropped.
  - Then raise `req`: `dout` sequence is 10..17 and 99 never appears.
- Hold `req` high for 5 cycles on an empty FIFO, then push 42.
  - `starve`=5 at the push edge, then stops incrementing.
  - `ack` arrives 2 edges after the push with `dout`=42.
- Keep `level` at 4; run a continuous push stream with `req` high.
  - Simultaneous push/grant cycles leave `level` unchanged.
  - Pointers wrap past `depth`−1 with in-order data over 40 words.
- Requester that drops `req` one cycle after `ack`: never two consecutive `ack` cycles and no word is lost.
- Assert `rst` for 1 cycle with `level`=5 and `ack` high.
  - Next cycle: `ack`=0, `level`=0, `count`=0, `dout`=0.
  - A subsequent push of 7 is granted as `dout`=7.
